// File: rtl/spi_txn_sequencer.sv
// Command/response sequencer in front of spi_master: one SPI transfer per queued
// command, with done-edge detection, a WAIT timeout and rejection of select 3.
module spi_txn_sequencer #(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_sel,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [1:0] rsp_sel,
  output logic       rsp_err,
  output logic       spi_start,
  output logic [1:0] spi_slave_sel,
  output logic [7:0] spi_mosi_data,
  input  logic       spi_done,
  input  logic [7:0] spi_miso_data,
  output logic       busy
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);
  localparam int TW  = $clog2(TIMEOUT);

  localparam logic [CAW:0]  CMD_FULL_CNT = (CAW + 1)'(CMD_DEPTH);
  localparam logic [RAW:0]  RSP_FULL_CNT = (RAW + 1)'(RSP_DEPTH);
  localparam logic [TW-1:0] T_LAST       = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_STORE = 2'd3;

  logic [1:0] state;

  // ---------------- command FIFO: {sel, data} ----------------
  logic [9:0]     cmd_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wr_ptr, cmd_rd_ptr;
  logic [CAW:0]   cmd_count;
  logic           cmd_full, cmd_empty, cmd_push, cmd_pop;

  // ---------------- response FIFO: {sel, data, err} ----------------
  logic [10:0]    rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] rsp_wr_ptr, rsp_rd_ptr;
  logic [RAW:0]   rsp_count;
  logic           rsp_full, rsp_push, rsp_pop;
  logic [10:0]    rsp_head;

  logic [7:0]     rsp_byte;
  logic           rsp_err_q;
  logic [TW-1:0]  tcnt;
  logic           done_q, done_rise;

  assign cmd_full  = (cmd_count == CMD_FULL_CNT);
  assign cmd_empty = (cmd_count == '0);
  assign cmd_ready = ~cmd_full;
  assign cmd_push  = cmd_valid & ~cmd_full;
  // Only start a command when its response is guaranteed a slot at STORE time.
  assign cmd_pop   = (state == S_IDLE) & ~cmd_empty & ~rsp_full;

  assign rsp_full  = (rsp_count == RSP_FULL_CNT);
  assign rsp_valid = (rsp_count != '0);
  assign rsp_push  = (state == S_STORE);
  assign rsp_pop   = rsp_valid & rsp_ready;
  assign rsp_head  = rsp_mem[rsp_rd_ptr];
  assign rsp_sel   = rsp_valid ? rsp_head[10:9] : 2'd0;
  assign rsp_data  = rsp_valid ? rsp_head[8:1]  : 8'd0;
  assign rsp_err   = rsp_valid ? rsp_head[0]    : 1'b0;

  assign spi_start = (state == S_ISSUE);
  assign busy      = (state != S_IDLE) | ~cmd_empty;
  assign done_rise = spi_done & ~done_q;

  // NOTE: storage arrays carry no reset; the pointers/counts define validity,
  // which keeps them mappable to plain RAM and out of the reset tree.
  always_ff @(posedge clk) begin
    if (cmd_push) cmd_mem[cmd_wr_ptr] <= {cmd_sel, cmd_data};
    if (rsp_push) rsp_mem[rsp_wr_ptr] <= {spi_slave_sel, rsp_byte, rsp_err_q};
  end

  // NOTE: all clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wr_ptr <= '0;
      cmd_rd_ptr <= '0;
      cmd_count  <= '0;
      rsp_wr_ptr <= '0;
      rsp_rd_ptr <= '0;
      rsp_count  <= '0;
    end else begin
      if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + 1'b1;
      if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + 1'b1;
      case ({cmd_push, cmd_pop})
        2'b10:   cmd_count <= cmd_count + 1'b1;
        2'b01:   cmd_count <= cmd_count - 1'b1;
        default: cmd_count <= cmd_count;
      endcase
      if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
      if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
      case ({rsp_push, rsp_pop})
        2'b10:   rsp_count <= rsp_count + 1'b1;
        2'b01:   rsp_count <= rsp_count - 1'b1;
        default: rsp_count <= rsp_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      spi_slave_sel <= 2'd0;
      spi_mosi_data <= 8'd0;
      rsp_byte      <= 8'd0;
      rsp_err_q     <= 1'b0;
      tcnt          <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q <= spi_done;
      case (state)
        S_IDLE: begin
          if (cmd_pop) begin
            {spi_slave_sel, spi_mosi_data} <= cmd_mem[cmd_rd_ptr];
            if (cmd_mem[cmd_rd_ptr][9:8] == 2'd3) begin
              rsp_byte  <= 8'h00;
              rsp_err_q <= 1'b1;
              state     <= S_STORE;
            end else begin
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // done takes priority over a timeout landing in the same cycle
          if (done_rise) begin
            rsp_byte  <= spi_miso_data;
            rsp_err_q <= 1'b0;
            state     <= S_STORE;
          end else if (tcnt == T_LAST) begin
            rsp_byte  <= 8'hFF;
            rsp_err_q <= 1'b1;
            state     <= S_STORE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spi_txn_sequencer.md
Name: spi_txn_sequencer

Overview:
Command/response front end that sits directly upstream of spi_master and drives its start/slave_sel/mosi_data inputs. Software-side logic pushes {slave select, byte} commands into a command FIFO. The sequencer issues one SPI transfer per command, waits for spi_master's done, and pushes the captured MISO byte, with select and error flag, into a response FIFO. It also adds a done timeout and rejects the invalid select value 3.

Parameters:
CMD_DEPTH, 4, command FIFO entries; power of 2, at least 2
RSP_DEPTH, 4, response FIFO entries; power of 2, at least 2
TIMEOUT, 1024, max clk cycles spent in WAIT before a transfer is declared failed; at least 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command push request
cmd_ready  out  1  command FIFO not full
cmd_sel  in  2  target slave (0..2 valid)
cmd_data  in  8  byte to send on MOSI
rsp_valid  out  1  response FIFO not empty
rsp_ready  in  1  response pop
rsp_data  out  8  received MISO byte
rsp_sel  out  2  slave the response came from
rsp_err  out  1  1 = timeout or invalid select
spi_start  out  1  to spi_master.start
spi_slave_sel  out  2  to spi_master.slave_sel
spi_mosi_data  out  8  to spi_master.mosi_data
spi_done  in  1  from spi_master.done
spi_miso_data  in  8  from spi_master.miso_data
busy  out  1  FSM not IDLE or command FIFO not empty

Behaviour:
- Clock, reset and FIFOs
  - One clock (clk); reset is asynchronous and active-high (rst).
  - On reset: FSM goes to IDLE, both FIFOs empty, and all outputs are 0, including spi_start, spi_slave_sel, spi_mosi_data, rsp_valid and busy.
  - cmd_ready is 1 after reset.
  - Command push occurs when cmd_valid & cmd_ready. cmd_ready = !cmd_full. A push is refused when the FIFO is full, even if a pop happens in the same cycle.
  - The response FIFO is first-word fall-through: rsp_* show the head entry while rsp_valid=1, and a pop occurs when rsp_valid & rsp_ready. Push and pop in the same cycle are allowed, and the count is unchanged.
- IDLE state
  - Leaves IDLE only when the command FIFO is non-empty AND the response FIFO has at least one free slot. This guarantees the later STORE never overflows.
  - On leaving, pops the command and latches sel/data into spi_slave_sel/spi_mosi_data.
  - If sel == 3, goes to STORE with data=0x00, err=1. No SPI activity occurs.
  - Otherwise goes to ISSUE.
- ISSUE state (1 cycle)
  - spi_start=1 for exactly this cycle.
  - Timeout counter is cleared to 0.
  - Goes to WAIT.
- WAIT state
  - Edge detection: done_q is the registered spi_done, and done_rise = spi_done & !done_q. done_q updates every cycle, so done already high during ISSUE does not complete the transfer.
  - On done_rise, spi_miso_data is captured and the FSM goes to STORE with err=0.
  - If the counter reaches TIMEOUT-1 without done_rise, the FSM goes to STORE with data=0xFF, err=1.
  - If done_rise and the timeout coincide, done wins.
- STORE state (1 cycle)
  - Pushes {sel, data, err} into the response FIFO.
  - Returns to IDLE.
- Timing and holding rules
  - spi_slave_sel and spi_mosi_data are held stable from the IDLE-exit cycle through STORE, and keep their values in IDLE.
  - Per-command overhead around the SPI transfer is 3 cycles (IDLE exit, ISSUE, STORE). Back-to-back commands produce a spi_start every (W+3) cycles, where W is the number of WAIT cycles.
  - Responses come out in command order.
- Reset during operation
  - rst asserted mid-WAIT aborts the transfer: spi_start is 0 immediately, and both FIFOs are flushed.
  - spi_master shares rst, so both sides restart clean.
- rsp_ready held low
  - The response FIFO fills, and the sequencer then stalls in IDLE with commands retained.
  - No command is lost or dropped.

Test Plan:
1. Reset, slaves tx0=A5/tx1=3C/tx2=F0; push {0,5A} -> exactly one spi_start pulse with spi_slave_sel=0 and spi_mosi_data=5A; response {sel=0, data=A5, err=0}; slave0 rx=5A.
2. Push {0,5A},{1,C3},{2,0F} back-to-back with rsp_ready=1 -> responses in order A5/3C/F0 with sel 0/1/2, err=0; slaves rx 5A/C3/0F; busy falls after the third STORE.
3. Push {3,11} -> no spi_start; response {sel=3, data=00, err=1} 2 cycles after the push.
4. TIMEOUT=16, spi_done tied 0, push {1,77} -> response {sel=1, data=FF, err=1} 16 WAIT cycles after spi_start; the next command proceeds normally.
5. rsp_ready=0, push 6 commands with CMD_DEPTH=RSP_DEPTH=4 -> cmd_ready drops once the command FIFO is full and exactly 4 transfers are issued, then the sequencer stalls. Raising rsp_ready drains all 6 responses in order.
6. Assert rst mid-WAIT of {2,0F} -> spi_start=0, rsp_valid=0, cmd_ready=1, busy=0 immediately; a new {0,5A} after release completes normally with data A5.
